// File: rtl/ascon_bdi_packer.sv
// Byte-to-word packer feeding the Ascon core bdi port: little-endian lanes, byte mask, eot/eoi framing.
// Optional type-mismatch detection with sticky err output when ASCON_BDI_PACKER_ERR_EN is defined.
module ascon_bdi_packer #(
  parameter int CCW = 32,
  localparam int CCWD8 = CCW / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [3:0]       s_type,
  input  logic             s_last,
  input  logic             s_final,
  output logic [CCW-1:0]   bdi,
  output logic [CCWD8-1:0] bdi_valid,
  input  logic             bdi_ready,
  output logic [3:0]       bdi_type,
  output logic             bdi_eot,
  output logic             bdi_eoi,
  output logic             busy
`ifdef ASCON_BDI_PACKER_ERR_EN
  ,
  output logic             err
`endif
);

  localparam int CNT_W = $clog2(CCWD8 + 1);
  localparam logic [3:0] D_NULL = 4'd0;

  logic [CCW-1:0]   fill_data_q, fill_data_d;
  logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [3:0]       fill_type_q, fill_type_d;
  logic             fill_eot_q, fill_eot_d, fill_eoi_q, fill_eoi_d;
  logic             pending_q, pending_d;
  logic             out_valid_q, out_valid_d;
  logic [CCWD8-1:0] out_mask_q, out_mask_d;
  logic [CCW-1:0]   out_data_q, out_data_d;
  logic [3:0]       out_type_q, out_type_d;
  logic             out_eot_q, out_eot_d, out_eoi_q, out_eoi_d;
`ifdef ASCON_BDI_PACKER_ERR_EN
  logic             err_q, err_d;
`endif

  logic             accept, out_free, drop, flush, complete;
  logic [CCW-1:0]   merged, word_data;
  logic [CNT_W-1:0] word_cnt;
  logic [3:0]       word_type;

  function automatic logic [CCWD8-1:0] mask_of(input logic [CNT_W-1:0] n);
    mask_of = '0;
    for (int i = 0; i < CCWD8; i++) mask_of[i] = (CNT_W'(i) < n);
  endfunction

  // NOTE: every always_comb output gets a default first, so no path can leave a latch behind.
  always_comb begin
    out_free  = !out_valid_q || bdi_ready;
    accept    = s_valid && !pending_q;
    word_type = (fill_cnt_q == '0) ? s_type : fill_type_q;
    merged    = fill_data_q | (CCW'(s_data) << (8 * fill_cnt_q));
`ifdef ASCON_BDI_PACKER_ERR_EN
    drop      = accept && (fill_cnt_q != '0) && (s_type != fill_type_q);
`else
    drop      = 1'b0;
`endif
    // A dropped last+final byte still closes the partial word so the core sees end-of-input.
    flush     = drop && s_last && s_final;
    complete  = (accept && !drop && (s_last || fill_cnt_q == CNT_W'(CCWD8 - 1))) || flush;
    word_cnt  = flush ? fill_cnt_q : fill_cnt_q + CNT_W'(1);
    word_data = flush ? fill_data_q : merged;

    fill_data_d = fill_data_q;
    fill_cnt_d  = fill_cnt_q;
    fill_type_d = fill_type_q;
    fill_eot_d  = fill_eot_q;
    fill_eoi_d  = fill_eoi_q;
    pending_d   = pending_q;
    out_valid_d = out_valid_q;
    out_mask_d  = out_mask_q;
    out_data_d  = out_data_q;
    out_type_d  = out_type_q;
    out_eot_d   = out_eot_q;
    out_eoi_d   = out_eoi_q;
`ifdef ASCON_BDI_PACKER_ERR_EN
    err_d       = err_q || drop;
`endif

    if (out_valid_q && bdi_ready) begin
      out_valid_d = 1'b0;
      out_mask_d  = '0;
      out_data_d  = '0;
      out_type_d  = D_NULL;
      out_eot_d   = 1'b0;
      out_eoi_d   = 1'b0;
    end

    if (pending_q) begin
      if (out_free) begin
        out_valid_d = 1'b1;
        out_mask_d  = mask_of(fill_cnt_q);
        out_data_d  = fill_data_q;
        out_type_d  = fill_type_q;
        out_eot_d   = fill_eot_q;
        out_eoi_d   = fill_eoi_q;
        pending_d   = 1'b0;
        fill_data_d = '0;
        fill_cnt_d  = '0;
        fill_type_d = D_NULL;
        fill_eot_d  = 1'b0;
        fill_eoi_d  = 1'b0;
      end
    end else if (complete) begin
      if (out_free) begin
        out_valid_d = 1'b1;
        out_mask_d  = mask_of(word_cnt);
        out_data_d  = word_data;
        out_type_d  = word_type;
        out_eot_d   = s_last;
        out_eoi_d   = s_last && s_final;
        fill_data_d = '0;
        fill_cnt_d  = '0;
        fill_type_d = D_NULL;
        fill_eot_d  = 1'b0;
        fill_eoi_d  = 1'b0;
      end else begin
        fill_data_d = word_data;
        fill_cnt_d  = word_cnt;
        fill_type_d = word_type;
        fill_eot_d  = s_last;
        fill_eoi_d  = s_last && s_final;
        pending_d   = 1'b1;
      end
    end else if (accept && !drop) begin
      fill_data_d = merged;
      fill_cnt_d  = word_cnt;
      fill_type_d = word_type;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_data_q <= '0;
      fill_cnt_q  <= '0;
      fill_type_q <= D_NULL;
      fill_eot_q  <= 1'b0;
      fill_eoi_q  <= 1'b0;
      pending_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_mask_q  <= '0;
      out_data_q  <= '0;
      out_type_q  <= D_NULL;
      out_eot_q   <= 1'b0;
      out_eoi_q   <= 1'b0;
`ifdef ASCON_BDI_PACKER_ERR_EN
      err_q       <= 1'b0;
`endif
    end else begin
      fill_data_q <= fill_data_d;
      fill_cnt_q  <= fill_cnt_d;
      fill_type_q <= fill_type_d;
      fill_eot_q  <= fill_eot_d;
      fill_eoi_q  <= fill_eoi_d;
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      out_mask_q  <= out_mask_d;
      out_data_q  <= out_data_d;
      out_type_q  <= out_type_d;
      out_eot_q   <= out_eot_d;
      out_eoi_q   <= out_eoi_d;
`ifdef ASCON_BDI_PACKER_ERR_EN
      err_q       <= err_d;
`endif
    end
  end

  assign s_ready   = !pending_q;
  assign bdi       = out_data_q;
  assign bdi_valid = out_valid_q ? out_mask_q : '0;
  assign bdi_type  = out_type_q;
  assign bdi_eot   = out_eot_q;
  assign bdi_eoi   = out_eoi_q;
  assign busy      = (fill_cnt_q != '0) || pending_q || out_valid_q;
`ifdef ASCON_BDI_PACKER_ERR_EN
  assign err       = err_q;
`endif

endmodule

// File: tb/tb_ascon_bdi_packer.sv
// Directed bench for ascon_bdi_packer (CCW=32): framing, back-pressure, reset and optional err path.
module tb_ascon_bdi_packer;

  localparam logic [3:0] D_NULL = 4'd0, D_NONCE = 4'd1, D_AD = 4'd2, D_MSG = 4'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_data;
  logic        s_valid, s_ready, s_last, s_final;
  logic [3:0]  s_type;
  logic [31:0] bdi;
  logic [3:0]  bdi_valid, bdi_type;
  logic        bdi_ready, bdi_eot, bdi_eoi, busy;
`ifdef ASCON_BDI_PACKER_ERR_EN
  logic        err;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  mask;
    logic [3:0]  typ;
    logic        eot;
    logic        eoi;
  } word_t;

  word_t q[$];
  word_t mon_w;

  ascon_bdi_packer #(.CCW(32)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_type(s_type),
    .s_last(s_last), .s_final(s_final),
    .bdi(bdi), .bdi_valid(bdi_valid), .bdi_ready(bdi_ready), .bdi_type(bdi_type),
    .bdi_eot(bdi_eot), .bdi_eoi(bdi_eoi), .busy(busy)
`ifdef ASCON_BDI_PACKER_ERR_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  // Words are captured mid-cycle; the handshake itself happens on the following rising edge.
  always @(negedge clk) begin
    if (!rst && bdi_valid != 4'd0 && bdi_ready) begin
      mon_w.data = bdi;
      mon_w.mask = bdi_valid;
      mon_w.typ  = bdi_type;
      mon_w.eot  = bdi_eot;
      mon_w.eoi  = bdi_eoi;
      q.push_back(mon_w);
    end
  end

  function automatic word_t mk(input logic [31:0] d, input logic [3:0] m, input logic [3:0] t,
                               input logic eot, input logic eoi);
    word_t w;
    w.data = d; w.mask = m; w.typ = t; w.eot = eot; w.eoi = eoi;
    return w;
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic [3:0] t, input logic l, input logic f);
    int n = 0;
    s_data = d; s_type = t; s_last = l; s_final = f; s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout byte=%h s_ready=%b required=1", d, s_ready);
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0; s_final = 1'b0;
  endtask

  task automatic wait_words(input int n);
    int c = 0;
    while (q.size() < n && c < 200) begin
      @(posedge clk);
      c++;
    end
    #1;
    if (q.size() < n) begin
      checks++; errors++;
      $display("FAIL word_timeout got=%0d words required=%0d", q.size(), n);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
    checks++; if (bdi !== 32'h0) begin errors++; $display("FAIL reset_bdi got=%h exp=0", bdi); end
    checks++; if (bdi_valid !== 4'h0) begin errors++; $display("FAIL reset_bdi_valid got=%h exp=0", bdi_valid); end
    checks++; if (bdi_type !== D_NULL) begin errors++; $display("FAIL reset_bdi_type got=%h exp=0", bdi_type); end
    checks++; if (bdi_eot !== 1'b0 || bdi_eoi !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b exp=00", bdi_eot, bdi_eoi); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
`ifdef ASCON_BDI_PACKER_ERR_EN
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_partial_tail();
    word_t exp[2];
    exp[0] = mk(32'h04030201, 4'b1111, D_AD, 1'b0, 1'b0);
    exp[1] = mk(32'h00000005, 4'b0001, D_AD, 1'b1, 1'b1);
    bdi_ready = 1'b1; q.delete();
    for (int i = 1; i <= 5; i++) send_byte(8'(i), D_AD, i == 5, i == 5);
    wait_words(2);
    idle(5);
    for (int i = 0; i < 2; i++) begin
      word_t got = (i < q.size()) ? q[i] : '0;
      checks++;
      if (got !== exp[i]) begin errors++; $display("FAIL partial_tail w%0d got=%h exp=%h", i, got, exp[i]); end
    end
    checks++; if (q.size() != 2) begin errors++; $display("FAIL partial_tail_count got=%0d exp=2", q.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL partial_tail_busy got=%b exp=0", busy); end
  endtask

  task automatic test_full_last();
    word_t exp[2];
    exp[0] = mk(32'h03020100, 4'b1111, D_MSG, 1'b0, 1'b0);
    exp[1] = mk(32'h07060504, 4'b1111, D_MSG, 1'b1, 1'b0);
    bdi_ready = 1'b1; q.delete();
    for (int i = 0; i < 8; i++) send_byte(8'(i), D_MSG, i == 7, 1'b0);
    wait_words(2);
    idle(6);
    for (int i = 0; i < 2; i++) begin
      word_t got = (i < q.size()) ? q[i] : '0;
      checks++;
      if (got !== exp[i]) begin errors++; $display("FAIL full_last w%0d got=%h exp=%h", i, got, exp[i]); end
    end
    checks++; if (q.size() != 2) begin errors++; $display("FAIL full_last_no_extra got=%0d words exp=2", q.size()); end
  endtask

  task automatic test_segments();
    word_t exp[5];
    exp[0] = mk(32'h13121110, 4'b1111, D_NONCE, 1'b0, 1'b0);
    exp[1] = mk(32'h17161514, 4'b1111, D_NONCE, 1'b0, 1'b0);
    exp[2] = mk(32'h1B1A1918, 4'b1111, D_NONCE, 1'b0, 1'b0);
    exp[3] = mk(32'h1F1E1D1C, 4'b1111, D_NONCE, 1'b1, 1'b0);
    exp[4] = mk(32'h00CCBBAA, 4'b0111, D_MSG, 1'b1, 1'b1);
    bdi_ready = 1'b1; q.delete();
    for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i), D_NONCE, i == 15, 1'b0);
    send_byte(8'hAA, D_MSG, 1'b0, 1'b0);
    send_byte(8'hBB, D_MSG, 1'b0, 1'b0);
    send_byte(8'hCC, D_MSG, 1'b1, 1'b1);
    wait_words(5);
    idle(4);
    for (int i = 0; i < 5; i++) begin
      word_t got = (i < q.size()) ? q[i] : '0;
      checks++;
      if (got !== exp[i]) begin errors++; $display("FAIL segments w%0d got=%h exp=%h", i, got, exp[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int idx = 0;
    int c = 0;
    logic [7:0] sb[$];
    bdi_ready = 1'b0; q.delete();
    // Ten cycles of continuous offer while the core stalls.
    for (int cyc = 0; cyc < 10; cyc++) begin
      s_data = 8'(8'h40 + idx); s_type = D_AD; s_last = (idx == 11); s_final = (idx == 11); s_valid = 1'b1;
      @(negedge clk);
      if (s_ready) idx++;
      @(posedge clk); #1;
    end
    checks++; if (idx != 8) begin errors++; $display("FAIL b2b_accepted got=%0d exp=8", idx); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL b2b_s_ready got=%b exp=0", s_ready); end
    checks++; if (bdi !== 32'h43424140 || bdi_valid !== 4'hF) begin
      errors++; $display("FAIL b2b_held got=%h/%h exp=43424140/f", bdi, bdi_valid);
    end
    bdi_ready = 1'b1;
    while (idx < 12 && c < 50) begin
      s_data = 8'(8'h40 + idx); s_type = D_AD; s_last = (idx == 11); s_final = (idx == 11); s_valid = 1'b1;
      @(negedge clk);
      if (s_ready) idx++;
      @(posedge clk); #1;
      c++;
    end
    s_valid = 1'b0; s_last = 1'b0; s_final = 1'b0;
    wait_words(3);
    idle(4);
    checks++; if (q.size() != 3) begin errors++; $display("FAIL b2b_words got=%0d exp=3", q.size()); end
    foreach (q[w]) for (int l = 0; l < 4; l++) if (q[w].mask[l]) sb.push_back(q[w].data[8*l +: 8]);
    checks++; if (sb.size() != 12) begin errors++; $display("FAIL b2b_bytes got=%0d exp=12", sb.size()); end
    for (int i = 0; i < 12; i++) begin
      logic [7:0] got = (i < sb.size()) ? sb[i] : 8'h00;
      checks++;
      if (got !== 8'(8'h40 + i)) begin errors++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, got, 8'(8'h40 + i)); end
    end
    if (q.size() == 3) begin
      checks++;
      if ({q[0].eot, q[1].eot, q[2].eot, q[2].eoi} !== 4'b0011) begin
        errors++; $display("FAIL b2b_flags got=%b exp=0011", {q[0].eot, q[1].eot, q[2].eot, q[2].eoi});
      end
    end
  endtask

  task automatic test_reset_mid();
    word_t exp;
    exp = mk(32'h00000011, 4'b0001, D_MSG, 1'b1, 1'b1);
    bdi_ready = 1'b0; q.delete();
    for (int i = 0; i < 6; i++) send_byte(8'(8'h50 + i), D_AD, 1'b0, 1'b0);
    checks++; if (busy !== 1'b1 || bdi_valid !== 4'hF) begin
      errors++; $display("FAIL rst_mid_pre busy=%b bdi_valid=%h exp=1/f", busy, bdi_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (bdi_valid !== 4'h0) begin errors++; $display("FAIL rst_mid_valid got=%h exp=0", bdi_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    #3 rst = 1'b0;
    @(posedge clk); #1;
    bdi_ready = 1'b1; q.delete();
    send_byte(8'h11, D_MSG, 1'b1, 1'b1);
    wait_words(1);
    idle(4);
    checks++; if (q.size() != 1) begin errors++; $display("FAIL rst_mid_count got=%0d exp=1", q.size()); end
    if (q.size() != 0) begin
      checks++;
      if (q[0] !== exp) begin errors++; $display("FAIL rst_mid_word got=%h exp=%h", q[0], exp); end
    end
  endtask

`ifdef ASCON_BDI_PACKER_ERR_EN
  task automatic test_err();
    word_t exp;
    exp = mk(32'h00000301, 4'b0011, D_AD, 1'b1, 1'b1);
    bdi_ready = 1'b1; q.delete();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_initial got=%b exp=0", err); end
    send_byte(8'h01, D_AD, 1'b0, 1'b0);
    send_byte(8'h02, D_MSG, 1'b0, 1'b0);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set got=%b exp=1", err); end
    send_byte(8'h03, D_AD, 1'b1, 1'b1);
    wait_words(1);
    idle(3);
    if (q.size() != 0) begin
      checks++;
      if (q[0] !== exp) begin errors++; $display("FAIL err_word got=%h exp=%h", q[0], exp); end
    end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", err); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; s_data = 8'h00; s_valid = 1'b0; s_type = D_NULL;
    s_last = 1'b0; s_final = 1'b0; bdi_ready = 1'b0;
    test_reset();
    test_partial_tail();
    test_full_last();
    test_segments();
    test_back_to_back();
    test_reset_mid();
`ifdef ASCON_BDI_PACKER_ERR_EN
    test_err();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
